// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, one full-adder cell reused LSB-first
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   synchronous active-low reset
//   start     request an operation (sampled only in IDLE)
//   sub       0: a+b+cin, 1: a-b-cin (cin is borrow-in); latched at start
//   a, b      operands, latched at start
//   cin       carry-in / borrow-in, latched at start
//   busy      high from the accepting edge until the result is posted
//   done      one-cycle pulse, result valid
//   sum       result, held until the next completion
//   cout      raw carry out of the MSB (sub: 1 = no borrow)
//   overflow  two's-complement signed overflow of the result
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic bit_s;
    logic bit_c;
    logic last;

    // Single full-adder cell, fed from the bit selected by the counter.
    assign bit_s = opa[cnt] ^ opb[cnt] ^ carry;
    assign bit_c = (opa[cnt] & opb[cnt]) | (opa[cnt] & carry) | (opb[cnt] & carry);
    assign last  = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            opa      <= '0;
            opb      <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1; a borrow-in removes the +1.
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        res   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    carry <= bit_c;
                    res   <= {bit_s, res[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        // carry here is the carry into the MSB.
                        sum      <= {bit_s, res[WIDTH-1:1]};
                        cout     <= bit_c;
                        overflow <= carry ^ bit_c;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub at widths 8, 4 and 16
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        sub;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    int          sel;

    always #5 clk = ~clk;

    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    serial_addsub #(.WIDTH(8)) u_w8 (
        .clk(clk), .reset_n(reset_n), .start(start && sel == 0), .sub(sub),
        .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_addsub #(.WIDTH(4)) u_w4 (
        .clk(clk), .reset_n(reset_n), .start(start && sel == 1), .sub(sub),
        .a(a[3:0]), .b(b[3:0]), .cin(cin),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
    );

    serial_addsub #(.WIDTH(16)) u_w16 (
        .clk(clk), .reset_n(reset_n), .start(start && sel == 2), .sub(sub),
        .a(a[15:0]), .b(b[15:0]), .cin(cin),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
    );

    logic        d_busy, d_done, d_cout, d_ovf;
    logic [31:0] d_sum;

    assign d_busy = (sel == 0) ? busy8 : (sel == 1) ? busy4 : busy16;
    assign d_done = (sel == 0) ? done8 : (sel == 1) ? done4 : done16;
    assign d_cout = (sel == 0) ? cout8 : (sel == 1) ? cout4 : cout16;
    assign d_ovf  = (sel == 0) ? ovf8  : (sel == 1) ? ovf4  : ovf16;
    assign d_sum  = (sel == 0) ? {24'b0, sum8} : (sel == 1) ? {28'b0, sum4} : {16'b0, sum16};

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (width %0d, t=%0t)", name, act, exp, cur_w(), $time);
        end
    endtask

    function automatic int cur_w();
        return (sel == 0) ? 8 : (sel == 1) ? 4 : 16;
    endfunction

    // Reference arithmetic: returns {overflow, cout, sum} from plain integer maths.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] ia, input logic [31:0] ib,
                                           input logic isub, input logic icin);
        longint mask, half, av, bv, sa, sb, u, s, c_in;
        logic   c, o;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        av   = longint'(ia) & mask;
        bv   = longint'(ib) & mask;
        sa   = (av >= half) ? av - (mask + 1) : av;
        sb   = (bv >= half) ? bv - (mask + 1) : bv;
        c_in = icin ? 1 : 0;
        if (!isub) begin
            u = av + bv + c_in;
            c = (u > mask);
            s = sa + sb + c_in;
        end else begin
            u = av - bv - c_in;
            c = (av >= bv + c_in);
            s = sa - sb - c_in;
        end
        o = (s > half - 1) || (s < -half);
        return {o, c, 32'(u & mask)};
    endfunction

    // Timing model: m_cnt counts edges since acceptance, -1 when idle.
    int          m_cnt   = -1;
    bit          m_valid = 1'b0;
    logic [31:0] m_sum, p_sum;
    logic        m_cout, m_ovf, p_cout, p_ovf;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_cnt   <= -1;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            if (m_cnt < 0) begin
                if (start) begin
                    {p_ovf, p_cout, p_sum} <= ref_op(cur_w(), a, b, sub, cin);
                    m_cnt <= 0;
                end
            end else begin
                if (m_cnt == cur_w() - 1) begin
                    m_sum  <= p_sum;
                    m_cout <= p_cout;
                    m_ovf  <= p_ovf;
                end
                if (m_cnt == cur_w()) m_cnt <= -1;
                else                  m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (m_valid) begin
            check("busy", 32'(d_busy), 32'(m_cnt >= 0 && m_cnt < cur_w()));
            check("done", 32'(d_done), 32'(m_cnt == cur_w()));
            check("sum",  d_sum, m_sum);
            check("cout", 32'(d_cout), 32'(m_cout));
            check("ovf",  32'(d_ovf), 32'(m_ovf));
        end
    end

    // Entered at a negedge where the next rising edge samples the DUT in IDLE.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub, input logic icin,
                          input bit lit, input logic [31:0] es, input int ec, input int eo, input bit hold);
        int cyc;
        bit seen;
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (d_done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("latency", 32'(cyc - 1), 32'(cur_w()));
            if (lit) begin
                check("sum_lit", d_sum, es);
                if (ec >= 0) check("cout_lit", 32'(d_cout), 32'(ec));
                if (eo >= 0) check("ovf_lit", 32'(d_ovf), 32'(eo));
            end
        end
        @(negedge clk);
    endtask

    task automatic switch_to(input int k);
        reset_n = 1'b0;
        start   = 1'b0;
        sel     = k;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0; sel = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("rst_busy", 32'(d_busy), 32'd0);
        check("rst_done", 32'(d_done), 32'd0);
        check("rst_sum", d_sum, 32'd0);

        // WIDTH = 8 directed cases
        run_op(32'h5A, 32'h33, 1'b0, 1'b0, 1'b1, 32'h8D, 0, 1, 1'b0);
        run_op(32'hFF, 32'h01, 1'b0, 1'b0, 1'b1, 32'h00, 1, 0, 1'b0);
        run_op(32'hFF, 32'h01, 1'b0, 1'b1, 1'b1, 32'h01, 1, 0, 1'b0);
        run_op(32'h10, 32'h20, 1'b1, 1'b0, 1'b1, 32'hF0, 0, 0, 1'b0);
        run_op(32'h80, 32'h01, 1'b1, 1'b0, 1'b1, 32'h7F, 1, 1, 1'b0);
        run_op(32'h50, 32'h20, 1'b1, 1'b1, 1'b1, 32'h2F, 1, 0, 1'b0);

        // start held and operands scrambled during RUN/DONE; next op only from IDLE
        run_op(32'h01, 32'h01, 1'b0, 1'b0, 1'b1, 32'h02, 0, 0, 1'b1);
        run_op(32'h03, 32'h04, 1'b0, 1'b0, 1'b1, 32'h07, 0, 0, 1'b0);

        // reset in the middle of an operation
        a = 32'h12; b = 32'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(d_busy), 32'd0);
        check("midrst_done", 32'(d_done), 32'd0);
        check("midrst_sum", d_sum, 32'd0);
        reset_n = 1'b1;
        run_op(32'h12, 32'h34, 1'b0, 1'b0, 1'b1, 32'h46, 0, 0, 1'b0);

        // WIDTH = 4: pin one case, then exhaustive sweep against the model
        switch_to(1);
        run_op(32'h7, 32'h1, 1'b0, 1'b0, 1'b1, 32'h8, 0, 1, 1'b0);
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int m = 0; m < 4; m++)
                    run_op(32'(ia), 32'(ib), m[1], m[0], 1'b0, 32'h0, -1, -1, 1'b0);

        // WIDTH = 16: zero-extended directed cases
        switch_to(2);
        run_op(32'h005A, 32'h0033, 1'b0, 1'b0, 1'b1, 32'h008D, 0, -1, 1'b0);
        run_op(32'h00FF, 32'h0001, 1'b0, 1'b0, 1'b1, 32'h0100, 0, -1, 1'b0);
        run_op(32'h00FF, 32'h0001, 1'b0, 1'b1, 1'b1, 32'h0101, 0, -1, 1'b0);
        run_op(32'h0010, 32'h0020, 1'b1, 1'b0, 1'b1, 32'hFFF0, 0, -1, 1'b0);
        run_op(32'h0080, 32'h0001, 1'b1, 1'b0, 1'b1, 32'h007F, 1, -1, 1'b0);
        run_op(32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b1, 32'h0000, 1, 0, 1'b0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
